// File: rtl/sprite_anim_sequencer.sv
// Walking-sprite sequencer: keyboard-driven facing/walk FSM, animation phase and clamped
// horizontal position, all advanced once per video frame tick.
module sprite_anim_sequencer #(
   parameter int unsigned HOLD_FRAMES = 4,
   parameter int unsigned STEP_PX     = 2,
   parameter int unsigned X_MIN       = 0,
   parameter int unsigned X_MAX       = 620,
   parameter int unsigned X_RESET     = 320
) (
   input  logic       Clk,
   input  logic       Reset,
   input  logic       frame_tick,
   input  logic [7:0] Keycode,
   output logic [3:0] motion,
   output logic [9:0] pos_x,
   output logic       moved,
   output logic       at_edge
);

   typedef enum logic [1:0] {StIdleR, StIdleL, StWalkR, StWalkL} state_e;

   localparam logic [10:0] XMinW    = 11'(X_MIN);
   localparam logic [10:0] XMaxW    = 11'(X_MAX);
   localparam logic [10:0] StepW    = 11'(STEP_PX);
   localparam logic [9:0]  XMin10   = 10'(X_MIN);
   localparam logic [9:0]  XMax10   = 10'(X_MAX);
   localparam logic [9:0]  XRst10   = 10'(X_RESET);
   localparam logic [9:0]  Step10   = 10'(STEP_PX);
   localparam logic [3:0]  HoldLast = 4'(HOLD_FRAMES - 1);

   state_e     state_q, state_d;
   logic [1:0] phase_q, phase_d;
   logic [3:0] hold_q, hold_d;
   logic [9:0] pos_q, pos_d;
   logic       moved_q, moved_d;

   logic        key_r, key_l, step_r, step_l;
   logic [10:0] pos_ext, sum_r;
   logic [9:0]  pos_r, pos_l;

   assign key_r = (Keycode == 8'd79);
   assign key_l = (Keycode == 8'd80);

   // Widened to 11 bits so the clamps can never wrap past 0 or 1023.
   assign pos_ext = {1'b0, pos_q};
   assign sum_r   = pos_ext + StepW;
   assign pos_r   = (sum_r > XMaxW) ? XMax10 : (pos_q + Step10);
   assign pos_l   = (pos_ext < (XMinW + StepW)) ? XMin10 : (pos_q - Step10);

   always_comb begin
      state_d = state_q;
      phase_d = phase_q;
      hold_d  = hold_q;
      step_r  = 1'b0;
      step_l  = 1'b0;
      if (frame_tick) begin
         unique case (state_q)
            StIdleR, StIdleL: begin
               if (key_r) begin
                  state_d = StWalkR;
                  phase_d = 2'd0;
                  hold_d  = 4'd0;
                  step_r  = 1'b1;
               end else if (key_l) begin
                  state_d = StWalkL;
                  phase_d = 2'd0;
                  hold_d  = 4'd0;
                  step_l  = 1'b1;
               end
            end
            StWalkR: begin
               if (key_r) begin
                  step_r = 1'b1;
                  if (pos_q == XMax10) begin
                     phase_d = 2'd0;
                     hold_d  = 4'd0;
                  end else if (hold_q == HoldLast) begin
                     hold_d  = 4'd0;
                     phase_d = phase_q + 2'd1;
                  end else begin
                     hold_d = hold_q + 4'd1;
                  end
               end else if (key_l) begin
                  state_d = StWalkL;
                  phase_d = 2'd0;
                  hold_d  = 4'd0;
                  step_l  = 1'b1;
               end else begin
                  state_d = StIdleR;
                  phase_d = 2'd0;
                  hold_d  = 4'd0;
               end
            end
            StWalkL: begin
               if (key_l) begin
                  step_l = 1'b1;
                  if (pos_q == XMin10) begin
                     phase_d = 2'd0;
                     hold_d  = 4'd0;
                  end else if (hold_q == HoldLast) begin
                     hold_d  = 4'd0;
                     phase_d = phase_q + 2'd1;
                  end else begin
                     hold_d = hold_q + 4'd1;
                  end
               end else if (key_r) begin
                  state_d = StWalkR;
                  phase_d = 2'd0;
                  hold_d  = 4'd0;
                  step_r  = 1'b1;
               end else begin
                  state_d = StIdleL;
                  phase_d = 2'd0;
                  hold_d  = 4'd0;
               end
            end
         endcase
      end
   end

   always_comb begin
      pos_d = pos_q;
      if (step_r) begin
         pos_d = pos_r;
      end else if (step_l) begin
         pos_d = pos_l;
      end
      moved_d = (pos_d != pos_q);
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state_q <= StIdleR;
         phase_q <= 2'd0;
         hold_q  <= 4'd0;
         pos_q   <= XRst10;
         moved_q <= 1'b0;
      end else begin
         state_q <= state_d;
         phase_q <= phase_d;
         hold_q  <= hold_d;
         pos_q   <= pos_d;
         moved_q <= moved_d;
      end
   end

   // Phase is always zero in the idle states, so it can feed motion directly.
   always_comb begin
      motion = {2'b10, phase_q};
      if (state_q == StIdleL || state_q == StWalkL) begin
         motion = {2'b01, phase_q};
      end
   end

   assign pos_x   = pos_q;
   assign moved   = moved_q;
   assign at_edge = (pos_q == XMin10) || (pos_q == XMax10);

endmodule

// File: tb/tb_sprite_anim_sequencer.sv
// Scoreboard bench for sprite_anim_sequencer: a rule-level model queues the expected result of
// every frame tick and a monitor compares the outputs on every clock.
module tb_sprite_anim_sequencer;

   localparam int HOLD_FRAMES = 4;
   localparam int STEP_PX     = 2;
   localparam int X_MIN       = 0;
   localparam int X_MAX       = 620;
   localparam int X_RESET     = 320;

   logic       Clk = 1'b0;
   logic       Reset;
   logic       frame_tick;
   logic [7:0] Keycode;
   logic [3:0] motion;
   logic [9:0] pos_x;
   logic       moved;
   logic       at_edge;

   sprite_anim_sequencer #(
      .HOLD_FRAMES(HOLD_FRAMES),
      .STEP_PX    (STEP_PX),
      .X_MIN      (X_MIN),
      .X_MAX      (X_MAX),
      .X_RESET    (X_RESET)
   ) dut (
      .Clk       (Clk),
      .Reset     (Reset),
      .frame_tick(frame_tick),
      .Keycode   (Keycode),
      .motion    (motion),
      .pos_x     (pos_x),
      .moved     (moved),
      .at_edge   (at_edge)
   );

   always #5 Clk = ~Clk;

   typedef struct packed {
      logic [3:0] motion;
      logic [9:0] pos;
      logic       moved;
      logic       edge_hi;
   } exp_t;

   exp_t exp_q[$];
   exp_t last_exp;
   int   n_checks  = 0;
   int   n_errors  = 0;
   int   moved_cnt = 0;

   // Reference model: facing, walking flag, phase, hold count and position as plain integers.
   int m_pos, m_phase, m_hold;
   bit m_right, m_walk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic exp_t model_view(input bit mv);
      exp_t e;
      e.motion  = {m_right, !m_right, 2'(m_phase)};
      e.pos     = 10'(m_pos);
      e.moved   = mv;
      e.edge_hi = (m_pos == X_MIN) || (m_pos == X_MAX);
      return e;
   endfunction

   task automatic model_reset();
      m_pos   = X_RESET;
      m_phase = 0;
      m_hold  = 0;
      m_right = 1'b1;
      m_walk  = 1'b0;
      last_exp = model_view(1'b0);
   endtask

   task automatic model_step(input logic [7:0] key, output exp_t e);
      bit kr, kl, dir_r;
      int old, bound;
      kr  = (key == 8'd79);
      kl  = (key == 8'd80);
      old = m_pos;
      if (!kr && !kl) begin
         m_walk  = 1'b0;
         m_phase = 0;
         m_hold  = 0;
      end else begin
         dir_r = kr;
         bound = dir_r ? X_MAX : X_MIN;
         if (m_walk && (m_right == dir_r)) begin
            if (m_pos == bound) begin
               m_phase = 0;
               m_hold  = 0;
            end else if (m_hold == HOLD_FRAMES - 1) begin
               m_hold  = 0;
               m_phase = (m_phase + 1) % 4;
            end else begin
               m_hold++;
            end
         end else begin
            m_walk  = 1'b1;
            m_right = dir_r;
            m_phase = 0;
            m_hold  = 0;
         end
         if (dir_r) m_pos = (m_pos + STEP_PX > X_MAX) ? X_MAX : m_pos + STEP_PX;
         else       m_pos = (m_pos - STEP_PX < X_MIN) ? X_MIN : m_pos - STEP_PX;
      end
      e = model_view(m_pos != old);
   endtask

   // Monitor: ticks pop a queued expectation; other cycles must hold state with moved low.
   always @(posedge Clk) begin
      logic was_tick;
      was_tick = (frame_tick === 1'b1) && (Reset === 1'b0);
      #1;
      if (Reset === 1'b0) begin
         if (was_tick) begin
            if (exp_q.size() == 0) begin
               check("queue_empty_on_tick", 32'd1, 32'd0);
            end else begin
               last_exp = exp_q.pop_front();
            end
            check("tick_moved", {31'd0, moved}, {31'd0, last_exp.moved});
         end else begin
            check("hold_moved", {31'd0, moved}, 32'd0);
         end
         check("motion", {28'd0, motion}, {28'd0, last_exp.motion});
         check("pos_x", {22'd0, pos_x}, {22'd0, last_exp.pos});
         check("at_edge", {31'd0, at_edge}, {31'd0, last_exp.edge_hi});
         if (moved === 1'b1) moved_cnt++;
      end
   end

   task automatic do_tick(input logic [7:0] key);
      exp_t e;
      @(negedge Clk);
      Keycode    = key;
      frame_tick = 1'b1;
      model_step(key, e);
      exp_q.push_back(e);
      @(negedge Clk);
      frame_tick = 1'b0;
      Keycode    = 8'($urandom);
      repeat ($urandom_range(0, 2)) @(negedge Clk);
   endtask

   // Holds a tick with a walking key against reset to show reset wins.
   task automatic do_reset();
      @(negedge Clk);
      Reset      = 1'b1;
      frame_tick = 1'b1;
      Keycode    = 8'd79;
      #1;
      check("rst_motion", {28'd0, motion}, 32'h8);
      check("rst_pos", {22'd0, pos_x}, 32'd320);
      check("rst_moved", {31'd0, moved}, 32'd0);
      check("rst_edge", {31'd0, at_edge}, 32'd0);
      exp_q.delete();
      model_reset();
      @(negedge Clk);
      frame_tick = 1'b0;
      Keycode    = 8'd0;
      @(negedge Clk);
      Reset = 1'b0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [7:0] key;
      Reset      = 1'b1;
      frame_tick = 1'b0;
      Keycode    = 8'd0;
      model_reset();
      do_reset();

      // Nine ticks right from reset.
      moved_cnt = 0;
      repeat (9) do_tick(8'd79);
      check("walk9_pos", {22'd0, pos_x}, 32'd338);
      check("walk9_motion", {28'd0, motion}, 32'ha);
      check("walk9_moved_cnt", moved_cnt, 32'd9);

      // Reverse then release.
      do_tick(8'd80);
      check("rev_motion", {28'd0, motion}, 32'h4);
      check("rev_pos", {22'd0, pos_x}, 32'd336);
      do_tick(8'd0);
      check("idlel_motion", {28'd0, motion}, 32'h4);
      check("idlel_pos", {22'd0, pos_x}, 32'd336);
      check("idlel_moved", {31'd0, moved}, 32'd0);

      // Right bound.
      do_reset();
      repeat (150) do_tick(8'd79);
      check("rbound_pos", {22'd0, pos_x}, 32'd620);
      check("rbound_edge", {31'd0, at_edge}, 32'd1);
      for (int t = 151; t <= 160; t++) begin
         do_tick(8'd79);
         check("rbound_hold_pos", {22'd0, pos_x}, 32'd620);
         check("rbound_hold_edge", {31'd0, at_edge}, 32'd1);
         check("rbound_hold_moved", {31'd0, moved}, 32'd0);
         check("rbound_hold_motion", {28'd0, motion}, 32'h8);
      end

      // Left bound.
      do_reset();
      repeat (165) do_tick(8'd80);
      check("lbound_pos", {22'd0, pos_x}, 32'd0);
      check("lbound_motion", {28'd0, motion}, 32'h4);
      check("lbound_edge", {31'd0, at_edge}, 32'd1);

      // Key held without ticks, then an unrecognised key on a tick.
      do_reset();
      repeat (3) do_tick(8'd79);
      @(negedge Clk);
      Keycode = 8'd79;
      repeat (100) @(negedge Clk);
      check("notick_pos", {22'd0, pos_x}, 32'(m_pos));
      do_tick(8'd81);
      check("key81_motion", {28'd0, motion}, 32'h8);
      check("key81_pos", {22'd0, pos_x}, 32'd326);

      // Asynchronous reset mid-cycle while walking left in phase 2.
      do_reset();
      repeat (9) do_tick(8'd80);
      check("walkl_motion", {28'd0, motion}, 32'h6);
      check("walkl_pos", {22'd0, pos_x}, 32'd302);
      @(posedge Clk);
      #2;
      Reset = 1'b1;
      #1;
      exp_q.delete();
      model_reset();
      check("async_motion", {28'd0, motion}, 32'h8);
      check("async_pos", {22'd0, pos_x}, 32'd320);
      check("async_moved", {31'd0, moved}, 32'd0);
      @(negedge Clk);
      @(negedge Clk);
      Reset = 1'b0;

      // Randomised key runs.
      key = 8'd0;
      repeat (400) begin
         if ($urandom_range(0, 3) == 0) begin
            case ($urandom_range(0, 4))
               0:       key = 8'd79;
               1:       key = 8'd80;
               2:       key = 8'd0;
               3:       key = 8'd81;
               default: key = 8'($urandom);
            endcase
         end
         do_tick(key);
      end

      repeat (3) @(negedge Clk);
      check("queue_drained", exp_q.size(), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
